jtag_ir_decoded: RTL and testbench
==================================

Name: jtag_ir_decoded

Overview:
- Parametrised JTAG instruction register for the TAP.
- Shift/update IR with IEEE 1149.1 capture pattern (LSBs = 2'b01 plus status bits), reset to IDCODE, a shift-length checker, and one-hot decode of the public instructions.
- Driven by the TAP controller's Capture_IR/Shift_IR/Update_IR/Test_Logic_Reset strobes; SO_IR_OUT feeds the TDO mux; select outputs steer the data-register mux.

Parameters:
- IR_LENGTH, 5, instruction width in bits; must be >= 2.
- IDCODE_OPC, 5'b00001, IDCODE opcode; also the reset/TLR instruction.
- EXTEST_OPC, 5'b00000, EXTEST opcode.
- SAMPLE_OPC, 5'b00010, SAMPLE/PRELOAD opcode.
- BYPASS_OPC, all ones, BYPASS opcode.

Ports:
- TCK  input  1  TAP clock; all state changes on posedge.
- TRST  input  1  asynchronous active-low reset.
- Test_Logic_Reset  input  1  synchronous TLR strobe from the TAP FSM.
- Capture_IR  input  1  capture strobe.
- Shift_IR  input  1  shift strobe.
- Update_IR  input  1  update strobe.
- TDI  input  1  serial in.
- IR_STATUS  input  IR_LENGTH-2  status bits captured above the 01 pattern.
- SO_IR_OUT  output  1  serial out = shift register MSB.
- IR_OUT  output  IR_LENGTH  current (updated) instruction.
- SEL_IDCODE, SEL_EXTEST, SEL_SAMPLE, SEL_BYPASS  output  1 each  one-hot decode of IR_OUT.
- IR_LEN_ERR  output  1  sticky short-shift error.
- IR_PAR_ERR  output  1  sticky parity error (see Optional Feature).

Behaviour:
- Interface: one clock (TCK); reset TRST is asynchronous, active-low.
- Reset (TRST=0):
  - shift_reg = {IR_LENGTH-2 zeros, 2'b01}; update_reg = IDCODE_OPC.
  - Shift counter = 0; IR_LEN_ERR = 0; IR_PAR_ERR = 0.
  - Resulting outputs: SEL_IDCODE=1, others 0; SO_IR_OUT = shift_reg MSB.
- Strobe priority each posedge: Test_Logic_Reset > Capture_IR > Shift_IR > Update_IR. Only the highest active strobe acts.
- Test_Logic_Reset: same state as TRST reset except IR_LEN_ERR and IR_PAR_ERR are held (sticky until TRST).
- Capture_IR: shift_reg <= {IR_STATUS, 2'b01}; counter <= 0.
- Shift_IR:
  - shift_reg <= {shift_reg[IR_LENGTH-2:0], TDI}.
  - Counter increments, saturating at IR_LENGTH. Overshift is legal; only the last IR_LENGTH bits are kept.
- Update_IR:
  - If counter == IR_LENGTH: update_reg <= shift_reg.
  - Else (short shift, including Update with no Shift): update_reg unchanged; IR_LEN_ERR <= 1.
  - Counter <= 0 in both cases.
- Latency: IR_OUT and selects change on the posedge where Update_IR is sampled, i.e. visible the cycle after.
- Decode (combinational from update_reg only, never from shift_reg):
  - Match IDCODE_OPC / EXTEST_OPC / SAMPLE_OPC drives the corresponding SEL.
  - Anything else, including BYPASS_OPC and unassigned opcodes, drives SEL_BYPASS.
  - Exactly one SEL high at all times.
- SO_IR_OUT is combinational from the shift_reg MSB. No output glitches from TDI.
- No strobe active: all state holds.

Optional Feature:
- Macro: JTAG_IR_PARITY_EN.
- Defined:
  - Shift path is IR_LENGTH+1 bits; the extra LSB is an even-parity bit shifted last.
  - Capture loads the parity bit with XOR of the captured opcode field.
  - Counter target is IR_LENGTH+1.
  - On a full-length Update, if the XOR over all IR_LENGTH+1 bits is 1: update_reg <= BYPASS_OPC and IR_PAR_ERR <= 1 (sticky until TRST). Otherwise load the opcode bits.
  - SO_IR_OUT is still the shift-path MSB.
- Undefined: IR_PAR_ERR tied 0; behaviour exactly as above.

Test Plan (IR_LENGTH=5, default opcodes):
1. TRST low then high; no strobes -> IR_OUT=5'b00001, SEL_IDCODE=1, IR_LEN_ERR=0.
2. IR_STATUS=3'b101, Capture_IR 1 cycle, then read SO_IR_OUT over 5 Shift_IR cycles -> serial 1,0,1,0,1 (MSB first).
3. Capture; shift TDI 0,0,0,1,0 (5 cycles); Update -> IR_OUT=5'b00010, SEL_SAMPLE=1. Then shift 11111 and update -> SEL_BYPASS=1.
4. Capture; 3 shifts; Update -> IR_OUT unchanged, IR_LEN_ERR=1. Test_Logic_Reset -> IR_OUT=5'b00001, IR_LEN_ERR still 1.
5. Capture; 7 shifts of 0,0,0,0,0,0,0; Update -> IR_OUT=5'b00000, SEL_EXTEST=1. Opcode 5'b00111 -> SEL_BYPASS=1.
6. Capture, Shift_IR and Update_IR asserted together -> capture wins. TRST pulsed mid-shift -> IR_OUT=5'b00001 immediately, counter 0. With JTAG_IR_PARITY_EN, shift 00010 plus parity 0 -> IR_OUT=5'b11111, IR_PAR_ERR=1.

Source files
------------

// File: rtl/jtag_ir_decoded_if.sv
// Signal bundle between the TAP controller and the JTAG instruction register.
// master: TAP side (strobes, TDI, status). slave: IR side (SO, IR, selects, errors).
interface jtag_ir_decoded_if #(
   parameter int IR_LENGTH = 5
);
   logic                 Test_Logic_Reset;
   logic                 Capture_IR;
   logic                 Shift_IR;
   logic                 Update_IR;
   logic                 TDI;
   logic [IR_LENGTH-3:0] IR_STATUS;
   logic                 SO_IR_OUT;
   logic [IR_LENGTH-1:0] IR_OUT;
   logic                 SEL_IDCODE;
   logic                 SEL_EXTEST;
   logic                 SEL_SAMPLE;
   logic                 SEL_BYPASS;
   logic                 IR_LEN_ERR;
   logic                 IR_PAR_ERR;

   modport master (
      output Test_Logic_Reset, Capture_IR, Shift_IR, Update_IR,
      output TDI, IR_STATUS,
      input  SO_IR_OUT, IR_OUT,
      input  SEL_IDCODE, SEL_EXTEST, SEL_SAMPLE, SEL_BYPASS,
      input  IR_LEN_ERR, IR_PAR_ERR
   );

   modport slave (
      input  Test_Logic_Reset, Capture_IR, Shift_IR, Update_IR,
      input  TDI, IR_STATUS,
      output SO_IR_OUT, IR_OUT,
      output SEL_IDCODE, SEL_EXTEST, SEL_SAMPLE, SEL_BYPASS,
      output IR_LEN_ERR, IR_PAR_ERR
   );
endinterface

// File: rtl/jtag_ir_decoded.sv
// JTAG instruction register: capture/shift/update, length check, one-hot decode.
// Ports: TCK, TRST (async low), bus (slave). Optional macro: JTAG_IR_PARITY_EN.
module jtag_ir_decoded #(
   parameter int                   IR_LENGTH  = 5,
   parameter logic [IR_LENGTH-1:0] IDCODE_OPC = IR_LENGTH'(1),
   parameter logic [IR_LENGTH-1:0] EXTEST_OPC = IR_LENGTH'(0),
   parameter logic [IR_LENGTH-1:0] SAMPLE_OPC = IR_LENGTH'(2),
   parameter logic [IR_LENGTH-1:0] BYPASS_OPC = '1
) (
   input logic              TCK,
   input logic              TRST,
   jtag_ir_decoded_if.slave bus
);
`ifdef JTAG_IR_PARITY_EN
   localparam int SW = IR_LENGTH + 1;
`else
   localparam int SW = IR_LENGTH;
`endif
   localparam int CW = $clog2(SW + 1);
   localparam logic [CW-1:0] TGT = CW'(SW);
   localparam logic [IR_LENGTH-1:0] CAP_RST =
      {{(IR_LENGTH-2){1'b0}}, 2'b01};

   logic [SW-1:0]        sr;
   logic [SW-1:0]        sr_rst;
   logic [SW-1:0]        cap_val;
   logic [IR_LENGTH-1:0] cap_op;
   logic [IR_LENGTH-1:0] ur;
   logic [CW-1:0]        cnt;
   logic                 len_err;
   logic                 sel_id, sel_ex, sel_sa, sel_by;

   assign cap_op = {bus.IR_STATUS, 2'b01};

`ifdef JTAG_IR_PARITY_EN
   // Parity bit sits below the opcode so it is the last bit shifted in.
   logic par_err;
   assign sr_rst  = {CAP_RST, ^CAP_RST};
   assign cap_val = {cap_op, ^cap_op};
`else
   assign sr_rst  = CAP_RST;
   assign cap_val = cap_op;
`endif

   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST) begin
         sr      <= sr_rst;
         ur      <= IDCODE_OPC;
         cnt     <= '0;
         len_err <= 1'b0;
`ifdef JTAG_IR_PARITY_EN
         par_err <= 1'b0;
`endif
      end else if (bus.Test_Logic_Reset) begin
         sr  <= sr_rst;
         ur  <= IDCODE_OPC;
         cnt <= '0;
      end else if (bus.Capture_IR) begin
         sr  <= cap_val;
         cnt <= '0;
      end else if (bus.Shift_IR) begin
         sr <= {sr[SW-2:0], bus.TDI};
         if (cnt != TGT)
            cnt <= cnt + 1'b1;
      end else if (bus.Update_IR) begin
         cnt <= '0;
         if (cnt == TGT) begin
`ifdef JTAG_IR_PARITY_EN
            if (^sr) begin
               ur      <= BYPASS_OPC;
               par_err <= 1'b1;
            end else begin
               ur <= sr[SW-1 -: IR_LENGTH];
            end
`else
            ur <= sr;
`endif
         end else begin
            len_err <= 1'b1;
         end
      end
   end

   // Unmatched opcodes fall to BYPASS so exactly one select is high.
   always_comb begin
      sel_id = 1'b0;
      sel_ex = 1'b0;
      sel_sa = 1'b0;
      sel_by = 1'b0;
      unique case (1'b1)
         (ur == IDCODE_OPC): sel_id = 1'b1;
         (ur == EXTEST_OPC): sel_ex = 1'b1;
         (ur == SAMPLE_OPC): sel_sa = 1'b1;
         default:            sel_by = 1'b1;
      endcase
   end

   assign bus.SO_IR_OUT  = sr[SW-1];
   assign bus.IR_OUT     = ur;
   assign bus.SEL_IDCODE = sel_id;
   assign bus.SEL_EXTEST = sel_ex;
   assign bus.SEL_SAMPLE = sel_sa;
   assign bus.SEL_BYPASS = sel_by;
   assign bus.IR_LEN_ERR = len_err;
`ifdef JTAG_IR_PARITY_EN
   assign bus.IR_PAR_ERR = par_err;
`else
   assign bus.IR_PAR_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_jtag_ir_decoded.sv
// Directed bench for jtag_ir_decoded (IR_LENGTH=5, default opcodes).
// Inputs change at negedge, outputs sampled 1 time unit after posedge.
module tb_jtag_ir_decoded;
   logic TCK;
   logic TRST;
   int   n_chk;
   int   n_fail;

   jtag_ir_decoded_if #(.IR_LENGTH(5)) bus ();

   jtag_ir_decoded #(.IR_LENGTH(5)) dut (
      .TCK  (TCK),
      .TRST (TRST),
      .bus  (bus)
   );

   initial TCK = 1'b0;
   always #5 TCK = ~TCK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_sel(input string tag, input logic [3:0] exp);
      chk(tag, {28'd0, bus.SEL_IDCODE, bus.SEL_EXTEST,
                bus.SEL_SAMPLE, bus.SEL_BYPASS}, {28'd0, exp});
   endtask

   task automatic step(input logic tlr, input logic cap,
                       input logic sh, input logic upd,
                       input logic tdi);
      @(negedge TCK);
      bus.Test_Logic_Reset = tlr;
      bus.Capture_IR       = cap;
      bus.Shift_IR         = sh;
      bus.Update_IR        = upd;
      bus.TDI              = tdi;
      @(posedge TCK);
      #1;
   endtask

   task automatic shift_bits(input logic [4:0] op);
      for (int i = 4; i >= 0; i--)
         step(0, 0, 1, 0, op[i]);
`ifdef JTAG_IR_PARITY_EN
      step(0, 0, 1, 0, ^op);
`endif
   endtask

   task automatic load(input logic [4:0] op);
      step(0, 1, 0, 0, 0);
      shift_bits(op);
      step(0, 0, 0, 1, 0);
   endtask

   logic [4:0] pat;

   initial begin
      n_chk  = 0;
      n_fail = 0;
      bus.Test_Logic_Reset = 0;
      bus.Capture_IR       = 0;
      bus.Shift_IR         = 0;
      bus.Update_IR        = 0;
      bus.TDI              = 0;
      bus.IR_STATUS        = 3'b000;
      TRST = 1'b1;
      #2 TRST = 1'b0;
      #1;
      // 1: reset state
      chk("rst_ir", bus.IR_OUT, 5'b00001);
      chk_sel("rst_sel", 4'b1000);
      chk("rst_len", bus.IR_LEN_ERR, 1'b0);
      chk("rst_par", bus.IR_PAR_ERR, 1'b0);
      chk("rst_so", bus.SO_IR_OUT, 1'b0);
      @(negedge TCK) TRST = 1'b1;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("idle_ir", bus.IR_OUT, 5'b00001);

      // 2: capture pattern shifted out MSB first
      bus.IR_STATUS = 3'b101;
      step(0, 1, 0, 0, 0);
      pat = 5'b10101;
      for (int i = 4; i >= 0; i--) begin
         chk($sformatf("cap_so%0d", i), bus.SO_IR_OUT, pat[i]);
         step(0, 0, 1, 0, 0);
      end
      step(0, 0, 0, 0, 0);

      // 3: SAMPLE load then BYPASS load
      step(0, 1, 0, 0, 0);
      shift_bits(5'b00010);
      chk("noupd_ir", bus.IR_OUT, 5'b00001);
      step(0, 0, 0, 1, 0);
      chk("sample_ir", bus.IR_OUT, 5'b00010);
      chk_sel("sample_sel", 4'b0010);
      load(5'b11111);
      chk("bypass_ir", bus.IR_OUT, 5'b11111);
      chk_sel("bypass_sel", 4'b0001);
      chk("len_ok", bus.IR_LEN_ERR, 1'b0);

      // 4: short shift, then TLR
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      chk("short_ir", bus.IR_OUT, 5'b11111);
      chk("short_len", bus.IR_LEN_ERR, 1'b1);
      step(1, 0, 0, 0, 0);
      chk("tlr_ir", bus.IR_OUT, 5'b00001);
      chk_sel("tlr_sel", 4'b1000);
      chk("tlr_len", bus.IR_LEN_ERR, 1'b1);

      // 5: overshift keeps last bits; unassigned opcode
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++)
         step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      chk("extest_ir", bus.IR_OUT, 5'b00000);
      chk_sel("extest_sel", 4'b0100);
      load(5'b00111);
      chk("unasg_ir", bus.IR_OUT, 5'b00111);
      chk_sel("unasg_sel", 4'b0001);

      // 6: priority, async reset mid-shift
      step(0, 1, 0, 0, 0);
      shift_bits(5'b00010);
      step(0, 1, 1, 1, 0);
      chk("prio_ir", bus.IR_OUT, 5'b00111);
      chk("prio_so", bus.SO_IR_OUT, 1'b1);
      step(0, 0, 0, 1, 0);
      chk("prio_cnt_ir", bus.IR_OUT, 5'b00111);
      step(1, 1, 0, 0, 0);
      chk("tlr_cap_ir", bus.IR_OUT, 5'b00001);
      chk("tlr_cap_so", bus.SO_IR_OUT, 1'b0);
      load(5'b11111);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 1);
      step(0, 0, 1, 0, 1);
      #2 TRST = 1'b0;
      #1;
      chk("trst_ir", bus.IR_OUT, 5'b00001);
      chk_sel("trst_sel", 4'b1000);
      chk("trst_len", bus.IR_LEN_ERR, 1'b0);
      @(negedge TCK);
      bus.Shift_IR = 0;
      TRST = 1'b1;
      for (int i = 0; i < 4; i++)
         step(0, 0, 1, 0, 1);
      step(0, 0, 0, 1, 0);
      chk("trst_cnt_ir", bus.IR_OUT, 5'b00001);
      chk("trst_cnt_len", bus.IR_LEN_ERR, 1'b1);

`ifdef JTAG_IR_PARITY_EN
      step(0, 1, 0, 0, 0);
      pat = 5'b00010;
      for (int i = 4; i >= 0; i--)
         step(0, 0, 1, 0, pat[i]);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      chk("par_ir", bus.IR_OUT, 5'b11111);
      chk("par_err", bus.IR_PAR_ERR, 1'b1);
`else
      chk("par_tied", bus.IR_PAR_ERR, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
